uart_tx_cfg: RTL and testbench

Configurable UART transmitter. A small write FIFO feeds a framing state machine that serialises bytes onto `tx`. Data width and FIFO depth are set by parameters. The baud divisor, parity mode and stop-bit count are runtime inputs, so software can reconfigure the link without a rebuild. It sits between the CPU bus UART register block and the board TX pin, and supersedes the fixed 8N1, single-byte, busy-gated transmitter.

---
 rtl/uart_tx_cfg.sv | 219 +++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   Configurable UART transmitter. A small write FIFO feeds a framing state
//   machine (start, DATA_BITS data bits LSB-first, optional parity, one or two
//   stop bits) that drives the registered serial output tx.
//
//   Parameters
//     DATA_BITS  data bits per frame (5..9)
//     FIFO_DEPTH write FIFO entries (power of two, >= 2)
//     DIV_W      width of the baud divisor
//
//   Ports
//     clk        system clock
//     rst        synchronous active-high reset
//     divisor    clocks per bit (0 behaves as 1), latched at each pop
//     parity_en  append a parity bit, latched at each pop
//     parity_odd odd (1) / even (0) parity, latched at each pop
//     two_stop   two stop bits when 1, latched at each pop
//     we, din    write strobe and data; dropped while full
//     full       FIFO full
//     overflow   one-cycle pulse after a write that was dropped
//     busy       frame in progress or FIFO non-empty
//     tx         serial output, idles high
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     divisor,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 we,
  input  logic [DATA_BITS-1:0] din,
  output logic                 full,
  output logic                 overflow,
  output logic                 busy,
  output logic                 tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 two_stop_q, two_stop_d;
  logic [DIV_W-1:0]     bit_time_q, bit_time_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;

  logic                 empty;
  logic                 full_w;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // that differ only in the wrap bit mean full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  // full is judged on the registered pointers, so a same-cycle pop never
  // makes room for a write.
  assign push    = we && !full_w;
  assign bit_end = (cnt_q == bit_time_q - ONE);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    bit_time_d = bit_time_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pop        = 1'b0;
    tx_d       = 1'b1;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 4'(DATA_BITS - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!two_stop_q || idx_q == 4'd1) begin
            // Last stop bit: chain straight into the next start bit when
            // another byte is waiting, so frames leave no idle gap.
            if (!empty) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pop also snapshots the link configuration, so mid-frame changes to
    // the config inputs only apply from the next byte.
    if (pop) begin
      state_d    = S_START;
      cnt_d      = '0;
      idx_d      = '0;
      shift_d    = head;
      par_bit_d  = (^head) ^ parity_odd;
      par_en_d   = parity_en;
      two_stop_d = two_stop;
      bit_time_d = (divisor == '0) ? ONE : divisor;
    end

    // tx is registered: drive the level belonging to the next state.
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  assign ovf_d    = we && full_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      bit_time_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      bit_time_q <= bit_time_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
    end
  end

  // Data storage carries no reset; it is only read after a valid push/pop.
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    par_bit_q <= par_bit_d;
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  assign full     = full_w;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE) || !empty;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: an 8-bit and a 7-bit instance, randomized and
// directed stimulus, expected tx waveforms built from the frame format.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] divisor;
  logic        parity_en, parity_odd, two_stop;
  logic        we8;
  logic [7:0]  din8;
  logic        full8, ovf8, busy8, tx8;
  logic        we7;
  logic [6:0]  din7;
  logic        full7, ovf7, busy7, tx7;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int wdata[$];
  int full_seen;
  int ovf_seen;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .divisor(divisor), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .we(we8), .din(din8),
    .full(full8), .overflow(ovf8), .busy(busy8), .tx(tx8)
  );

  uart_tx_cfg #(.DATA_BITS(7), .FIFO_DEPTH(4), .DIV_W(16)) u_dut7 (
    .clk(clk), .rst(rst), .divisor(divisor), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .we(we7), .din(din7),
    .full(full7), .overflow(ovf7), .busy(busy7), .tx(tx7)
  );

  function automatic logic obs_tx(input bit s7);
    return s7 ? tx7 : tx8;
  endfunction
  function automatic logic obs_busy(input bit s7);
    return s7 ? busy7 : busy8;
  endfunction
  function automatic logic obs_full(input bit s7);
    return s7 ? full7 : full8;
  endfunction
  function automatic logic obs_ovf(input bit s7);
    return s7 ? ovf7 : ovf8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one frame as a list of line levels, each held for
  // max(div,1) clocks, appended to the expected waveform.
  task automatic add_frame(input int nbits, input int data, input int div,
                           input bit pe, input bit po, input bit ts);
    int bt;
    bit lv[$];
    bit p;
    bt = (div == 0) ? 1 : div;
    p  = 1'b0;
    lv.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      lv.push_back(((data >> i) & 1) == 1);
      p = p ^ (((data >> i) & 1) == 1);
    end
    if (pe) lv.push_back(po ? !p : p);
    lv.push_back(1'b1);
    if (ts) lv.push_back(1'b1);
    foreach (lv[k]) begin
      for (int r = 0; r < bt; r++) exp_q.push_back(lv[k]);
    end
  endtask

  task automatic write_burst(input bit s7);
    foreach (wdata[i]) begin
      if (s7) begin
        we7  = 1'b1;
        din7 = 7'(wdata[i]);
      end else begin
        we8  = 1'b1;
        din8 = 8'(wdata[i]);
      end
      tick();
    end
    we7 = 1'b0;
    we8 = 1'b0;
  endtask

  task automatic sample_flags(input bit s7);
    if (obs_full(s7) === 1'b1) full_seen++;
    if (obs_ovf(s7) === 1'b1) ovf_seen++;
  endtask

  // Waits (bounded) for the start bit, then compares tx and busy every cycle
  // against exp_q; optionally checks the line is idle right afterwards.
  task automatic expect_trace(input bit s7, input int max_wait,
                              input bit idle_after, input string name);
    int   w;
    bit   found;
    int   bad;
    logic got_tx, got_busy;
    w = 0; found = 1'b0; bad = -1; got_tx = 1'b0; got_busy = 1'b0;
    full_seen = 0;
    ovf_seen  = 0;
    while (!found && w < max_wait) begin
      @(negedge clk);
      sample_flags(s7);
      if (obs_tx(s7) === 1'b0) found = 1'b1;
      else w++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s start: tx=%b after %0d cycles, required 0", name, obs_tx(s7), max_wait);
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        sample_flags(s7);
      end
      if (bad < 0 && (obs_tx(s7) !== exp_q[i] || obs_busy(s7) !== 1'b1)) begin
        bad      = i;
        got_tx   = obs_tx(s7);
        got_busy = obs_busy(s7);
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s trace: cycle %0d tx=%b busy=%b, required tx=%b busy=1",
               name, bad, got_tx, got_busy, exp_q[bad]);
    end
    if (idle_after) begin
      @(negedge clk);
      sample_flags(s7);
      checks++;
      if (obs_tx(s7) !== 1'b1 || obs_busy(s7) !== 1'b0) begin
        errors++;
        $display("FAIL %s idle: tx=%b busy=%b, required tx=1 busy=0",
                 name, obs_tx(s7), obs_busy(s7));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; we8 = 1'b0; we7 = 1'b0; din8 = '0; din7 = '0;
    divisor = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (tx8 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx8); end
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy8); end
    checks++;
    if (full8 !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, required 0", full8); end
    checks++;
    if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", ovf8); end
    checks++;
    if (tx7 !== 1'b1 || busy7 !== 1'b0) begin
      errors++; $display("FAIL reset_dut7: tx=%b busy=%b, required tx=1 busy=0", tx7, busy7);
    end
  endtask

  task automatic test_8n1();
    divisor = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    exp_q.delete();
    add_frame(8, 'hA5, 4, 1'b0, 1'b0, 1'b0);
    wdata = '{'hA5};
    write_burst(1'b0);
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b1 || tx8 !== 1'b1) begin
      errors++; $display("FAIL 8n1_latency: busy=%b tx=%b, required busy=1 tx=1", busy8, tx8);
    end
    // The start bit must appear on the very next cycle.
    expect_trace(1'b0, 1, 1'b1, "8n1_a5");
  endtask

  task automatic test_parity7();
    for (int po = 0; po < 2; po++) begin
      divisor = 16'd2; parity_en = 1'b1; parity_odd = (po == 1); two_stop = 1'b1;
      exp_q.delete();
      add_frame(7, 'h03, 2, 1'b1, po == 1, 1'b1);
      wdata = '{'h03};
      write_burst(1'b1);
      expect_trace(1'b1, 2, 1'b1, po == 1 ? "7o2_03" : "7e2_03");
    end
  endtask

  task automatic test_back_to_back();
    divisor = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    exp_q.delete();
    wdata = '{'h11, 'h22, 'h33};
    foreach (wdata[i]) add_frame(8, wdata[i], 3, 1'b0, 1'b0, 1'b0);
    fork
      write_burst(1'b0);
      expect_trace(1'b0, 3, 1'b1, "b2b");
    join
    checks++;
    if (full_seen != 0) begin
      errors++; $display("FAIL b2b_full: full high on %0d cycles, required 0", full_seen);
    end
  endtask

  task automatic test_overflow();
    divisor = 16'd10; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    exp_q.delete();
    wdata.delete();
    for (int i = 0; i < 6; i++) wdata.push_back(int'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) add_frame(8, wdata[i], 10, 1'b0, 1'b0, 1'b0);
    fork
      begin
        write_burst(1'b0);
        checks++;
        if (full8 !== 1'b1 || ovf8 !== 1'b1) begin
          errors++; $display("FAIL ovf_flags: full=%b overflow=%b, required 1 1", full8, ovf8);
        end
      end
      expect_trace(1'b0, 3, 1'b1, "ovf_frames");
    join
    checks++;
    if (ovf_seen != 1) begin
      errors++; $display("FAIL ovf_pulse: overflow high %0d cycles, required 1", ovf_seen);
    end
  endtask

  task automatic test_div_change();
    divisor = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    exp_q.delete();
    wdata = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
    add_frame(8, wdata[0], 4, 1'b0, 1'b0, 1'b0);
    add_frame(8, wdata[1], 8, 1'b0, 1'b0, 1'b0);
    fork
      begin
        write_burst(1'b0);
        repeat (10) tick();
        divisor = 16'd8;
      end
      expect_trace(1'b0, 3, 1'b1, "div_change");
    join
  endtask

  task automatic test_reset_mid();
    int bad_cycles;
    divisor = 16'd5; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    wdata = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255))};
    write_burst(1'b0);
    repeat (15) tick();
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b, required 1", busy8); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || full8 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: tx=%b busy=%b full=%b, required 1 0 0", tx8, busy8, full8);
    end
    bad_cycles = 0;
    repeat (80) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || busy8 !== 1'b0) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++; $display("FAIL rstmid_quiet: %0d active cycles, required 0", bad_cycles);
    end
    tick();
    exp_q.delete();
    wdata = '{'h5A};
    add_frame(8, 'h5A, 5, 1'b0, 1'b0, 1'b0);
    write_burst(1'b0);
    expect_trace(1'b0, 2, 1'b1, "rstmid_recover");
  endtask

  task automatic test_random();
    int div, n;
    bit pe, po, ts, s7;
    for (int round = 0; round < 8; round++) begin
      div = int'($urandom_range(0, 5));
      pe  = 1'($urandom_range(0, 1));
      po  = 1'($urandom_range(0, 1));
      ts  = 1'($urandom_range(0, 1));
      s7  = (round % 2) == 1;
      n   = int'($urandom_range(1, 3));
      divisor = 16'(div); parity_en = pe; parity_odd = po; two_stop = ts;
      exp_q.delete();
      wdata.delete();
      for (int i = 0; i < n; i++) begin
        wdata.push_back(int'($urandom_range(0, s7 ? 127 : 255)));
        add_frame(s7 ? 7 : 8, wdata[i], div, pe, po, ts);
      end
      fork
        write_burst(s7);
        expect_trace(s7, 3, 1'b1, "random");
      join
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity7();
    test_back_to_back();
    test_overflow();
    test_div_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
